// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register specifiers, word type.
package y86_pkg;

  typedef logic [63:0] word_t;
  typedef logic [3:0]  reg_id_t;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam reg_id_t RNONE = 4'hF;
  localparam reg_id_t RSP   = 4'h4;

endpackage

// File: rtl/seq_decode_if.sv
// Decode-stage bundle: fetch/execute side drives the instruction fields and
// write-back values, decode returns the two operands.
interface seq_decode_if;
  import y86_pkg::*;

  logic [3:0] icode;
  reg_id_t    rA;
  reg_id_t    rB;
  logic       cnd;
  word_t      valE;
  word_t      valM;
  word_t      valA;
  word_t      valB;

  modport master (output icode, rA, rB, cnd, valE, valM, input valA, valB);
  modport slave  (input icode, rA, rB, cnd, valE, valM, output valA, valB);
endinterface

// File: rtl/seq_regfile.sv
// Fifteen 64-bit program registers: two combinational read ports, two write
// ports where the M port wins over the E port on a shared destination.
module seq_regfile
  import y86_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  reg_id_t src_a,
  input  reg_id_t src_b,
  input  reg_id_t dst_e,
  input  reg_id_t dst_m,
  input  word_t   val_e,
  input  word_t   val_m,
  output word_t   val_a,
  output word_t   val_b
);

  word_t regs [0:14];

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_reg
      // Per-register write: reset loads the register's own index, M beats E.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs[gi] <= word_t'(gi);
        end else if (dst_m == reg_id_t'(gi)) begin
          regs[gi] <= val_m;
        end else if (dst_e == reg_id_t'(gi)) begin
          regs[gi] <= val_e;
        end
      end
    end
  endgenerate

  // RNONE is never stored, so it reads as zero; no write bypass.
  assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
  assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

endmodule

// File: rtl/seq_decode.sv
// Y86-64 SEQ decode/write-back: picks source and destination registers from
// the instruction fields and drives the register file.
module seq_decode
  import y86_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  seq_decode_if.slave bus
);

  reg_id_t src_a;
  reg_id_t src_b;
  reg_id_t dst_e;
  reg_id_t dst_m;

  // Register selection by instruction; unknown codes touch nothing.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.icode)
      IRRMOVQ: begin
        src_a = bus.rA;
        if (bus.cnd) dst_e = bus.rB;
      end
      IIRMOVQ: dst_e = bus.rB;
      IRMMOVQ: begin
        src_a = bus.rA;
        src_b = bus.rB;
      end
      IMRMOVQ: begin
        src_b = bus.rB;
        dst_m = bus.rA;
      end
      IOPQ: begin
        src_a = bus.rA;
        src_b = bus.rB;
        dst_e = bus.rB;
      end
      ICALL: begin
        src_b = RSP;
        dst_e = RSP;
      end
      IRET, IPOPQ: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
        if (bus.icode == IPOPQ) dst_m = bus.rA;
      end
      IPUSHQ: begin
        src_a = bus.rA;
        src_b = RSP;
        dst_e = RSP;
      end
      default: ;
    endcase
  end

  seq_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .src_a (src_a),
    .src_b (src_b),
    .dst_e (dst_e),
    .dst_m (dst_m),
    .val_e (bus.valE),
    .val_m (bus.valM),
    .val_a (bus.valA),
    .val_b (bus.valB)
  );

endmodule

// File: tb/tb_seq_decode.sv
// Directed bench for seq_decode: operand selection, write-back timing,
// M-over-E priority and asynchronous reset.
module tb_seq_decode;
  import y86_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  seq_decode_if bus ();

  seq_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive instruction fields and write-back values (blocking).
  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input word_t e, input word_t m);
    bus.icode = ic;
    bus.rA    = a;
    bus.rB    = b;
    bus.cnd   = c;
    bus.valE  = e;
    bus.valM  = m;
  endtask

  task automatic test_reset();
    drive(INOP, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    drive(IRMMOVQ, 4'd7, 4'd14, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (bus.valA !== 64'd7) begin errors++; $display("FAIL reset_r7 valA=%0d expected=7", bus.valA); end
    checks++; if (bus.valB !== 64'd14) begin errors++; $display("FAIL reset_r14 valB=%0d expected=14", bus.valB); end
    drive(INOP, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released, R[i]=i checked");
  endtask

  task automatic test_cmov_nocnd();
    @(negedge clk);
    drive(IRRMOVQ, 4'd0, 4'd1, 1'b0, 64'd99, 64'd0);
    #1;
    checks++; if (bus.valA !== 64'd0) begin errors++; $display("FAIL cmov_valA valA=%0d expected=0", bus.valA); end
    checks++; if (bus.valB !== 64'd0) begin errors++; $display("FAIL cmov_valB valB=%0d expected=0", bus.valB); end
    @(posedge clk); #1;
    drive(IRMMOVQ, 4'd0, 4'd1, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (bus.valB !== 64'd1) begin errors++; $display("FAIL cmov_nowrite R1=%0d expected=1", bus.valB); end
    drive(INOP, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    $display("cmov cnd=0: no write-back");
  endtask

  // Each vector is applied and checked inside one low clock phase, then
  // parked on a nop so no write happens at the following edge.
  task automatic test_select();
    logic [3:0] ic [10] = '{IRMMOVQ, IIRMOVQ, ICALL, IRET, IPOPQ, IPUSHQ, IMRMOVQ, IOPQ, IJXX, 4'hE};
    logic [3:0] ra [10] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd5, 4'd7, 4'd2, 4'hF, 4'd1, 4'd1};
    logic [3:0] rb [10] = '{4'd13, 4'd14, 4'd10, 4'd9, 4'd8, 4'd2, 4'd6, 4'd3, 4'd2, 4'd2};
    word_t      ea [10] = '{64'd1, 64'd0, 64'd0, 64'd4, 64'd4, 64'd7, 64'd0, 64'd0, 64'd0, 64'd0};
    word_t      eb [10] = '{64'd13, 64'd0, 64'd4, 64'd4, 64'd4, 64'd4, 64'd6, 64'd3, 64'd0, 64'd0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(ic[i], ra[i], rb[i], 1'b0, 64'hDEAD, 64'hBEEF);
      #1;
      checks++; if (bus.valA !== ea[i]) begin errors++; $display("FAIL select_valA icode=%h valA=%0d expected=%0d", ic[i], bus.valA, ea[i]); end
      checks++; if (bus.valB !== eb[i]) begin errors++; $display("FAIL select_valB icode=%h valB=%0d expected=%0d", ic[i], bus.valB, eb[i]); end
      $display("select icode=%h rA=%h rB=%h valA=%0d valB=%0d", ic[i], ra[i], rb[i], bus.valA, bus.valB);
      drive(INOP, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    drive(IOPQ, 4'd0, 4'd11, 1'b0, 64'd100, 64'd0);
    #1;
    checks++; if (bus.valB !== 64'd11) begin errors++; $display("FAIL opq_before valB=%0d expected=11", bus.valB); end
    @(posedge clk); #1;
    checks++; if (bus.valB !== 64'd100) begin errors++; $display("FAIL opq_after valB=%0d expected=100", bus.valB); end
    drive(IRRMOVQ, 4'd0, 4'd11, 1'b0, 64'd7, 64'd0);
    @(posedge clk); #1;
    drive(IRRMOVQ, 4'd1, 4'd12, 1'b1, 64'd77, 64'd0);
    @(posedge clk); #1;
    drive(IRMMOVQ, 4'd11, 4'd12, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (bus.valA !== 64'd100) begin errors++; $display("FAIL cmov_blocked R11=%0d expected=100", bus.valA); end
    checks++; if (bus.valB !== 64'd77) begin errors++; $display("FAIL cmov_taken R12=%0d expected=77", bus.valB); end
    drive(INOP, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    $display("write-back: R11=100, R12=77");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(IPOPQ, 4'd4, 4'hF, 1'b0, 64'd200, 64'd300);
    @(posedge clk); #1;
    drive(IRET, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (bus.valA !== 64'd300) begin errors++; $display("FAIL popq_rsp_valA valA=%0d expected=300", bus.valA); end
    checks++; if (bus.valB !== 64'd300) begin errors++; $display("FAIL popq_rsp_valB valB=%0d expected=300", bus.valB); end
    drive(IPOPQ, 4'd6, 4'hF, 1'b0, 64'd400, 64'd600);
    @(posedge clk); #1;
    drive(IMRMOVQ, 4'd0, 4'd4, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    checks++; if (bus.valB !== 64'd400) begin errors++; $display("FAIL popq_rsp_e valB=%0d expected=400", bus.valB); end
    drive(IRMMOVQ, 4'd6, 4'd0, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (bus.valA !== 64'd600) begin errors++; $display("FAIL popq_dst_m valA=%0d expected=600", bus.valA); end
    checks++; if (bus.valB !== 64'd0) begin errors++; $display("FAIL mrmov_dst_r0 valB=%0d expected=0", bus.valB); end
    drive(INOP, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    $display("popq: RSP=300 then RSP=400, R6=600");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(IIRMOVQ, 4'hF, 4'd3, 1'b0, 64'd55, 64'd0);
    @(posedge clk); #1;
    drive(IRMMOVQ, 4'd3, 4'd4, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (bus.valA !== 64'd55) begin errors++; $display("FAIL r3_written valA=%0d expected=55", bus.valA); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.valA !== 64'd3) begin errors++; $display("FAIL async_r3 valA=%0d expected=3", bus.valA); end
    checks++; if (bus.valB !== 64'd4) begin errors++; $display("FAIL async_rsp valB=%0d expected=4", bus.valB); end
    drive(IIRMOVQ, 4'hF, 4'd3, 1'b0, 64'd55, 64'd0);
    @(posedge clk); #1;
    drive(IRMMOVQ, 4'd3, 4'd4, 1'b0, 64'd0, 64'd0);
    #1;
    checks++; if (bus.valA !== 64'd3) begin errors++; $display("FAIL reset_blocks_write valA=%0d expected=3", bus.valA); end
    drive(INOP, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset: R3 back to 3, write blocked during reset");
  endtask

  initial begin
    test_reset();
    test_cmov_nocnd();
    test_select();
    test_write();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
